// File: rtl/mux4_pkg.sv
// Shared types for the 4:1 mux select sequencer: channel index and FSM states.
package mux4_pkg;
  localparam int NUM_CH = 4;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;
endpackage

// File: rtl/mux4_next_ch.sv
// Rotate-priority picker: first enabled channel searching upward from base+1,
// wrapping mod 4, with base itself checked last.
module mux4_next_ch
  import mux4_pkg::*;
(
  input  logic [NUM_CH-1:0] en_mask,
  input  ch_idx_t           base,
  output ch_idx_t           next,
  output logic              none
);

  ch_idx_t cand;

  always_comb begin
    next = base;
    cand = base;
    none = (en_mask == '0);
    // Walk from the farthest offset to the nearest so the nearest hit wins;
    // offset 4 wraps to base itself and therefore has the lowest priority.
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = base + 2'(k);
      if (en_mask[cand]) next = cand;
    end
  end

endmodule

// File: rtl/mux4_sel_sequencer.sv
// Steps the s1/s0 select of a downstream 4:1 mux through the enabled channels,
// holding each for max(dwell,1) cycles in round-robin order.
module mux4_sel_sequencer
  import mux4_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [NUM_CH-1:0]  en_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic               s1,
  output logic               s0,
  output logic               sel_valid,
  output logic               busy,
  output logic               ch_done
);

  // Control: start and stop are single-cycle level pulses sampled on the
  // rising edge; there is no ready/ack. stop wins over start, start is only
  // honoured in IDLE with a non-empty mask, and every output is decoded from
  // registers so nothing combinational reaches the pins from an input.

  localparam logic [DWELL_W-1:0] CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  seq_state_e         state, state_nxt;
  ch_idx_t            cur_ch, ch_nxt;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic [DWELL_W-1:0] dwell_ld;
  ch_idx_t            start_ch, adv_ch;
  logic               start_none, adv_none;
  logic               last_cycle;

  assign dwell_ld   = (dwell == '0) ? CNT_ONE : dwell;
  assign last_cycle = (cnt == CNT_ONE);

  // Base 3 makes the upward search begin at channel 0, i.e. lowest index first.
  mux4_next_ch u_start_pick (
    .en_mask (en_mask),
    .base    (2'd3),
    .next    (start_ch),
    .none    (start_none)
  );

  mux4_next_ch u_adv_pick (
    .en_mask (en_mask),
    .base    (cur_ch),
    .next    (adv_ch),
    .none    (adv_none)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cur_ch <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      cur_ch <= ch_nxt;
      cnt    <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ch_nxt    = cur_ch;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start && !stop && !start_none) begin
          state_nxt = RUN;
          ch_nxt    = start_ch;
          cnt_nxt   = dwell_ld;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (last_cycle) begin
          if (adv_none) begin
            state_nxt = IDLE;
          end else begin
            ch_nxt  = adv_ch;
            cnt_nxt = dwell_ld;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign s1        = cur_ch[1];
  assign s0        = cur_ch[0];
  assign sel_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign ch_done   = (state == RUN) && last_cycle;

endmodule

// File: tb/tb_mux4_sel_sequencer.sv
// Self-checking bench for mux4_sel_sequencer: directed scenarios plus random
// start/stop/mask/dwell traffic, compared cycle by cycle against a reference model.
module tb_mux4_sel_sequencer;

  localparam int DWELL_W = 8;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               stop;
  logic [3:0]         en_mask;
  logic [DWELL_W-1:0] dwell;
  logic               s1, s0, sel_valid, busy, ch_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: running flag, channel on the mux, cycles left.
  bit m_run;
  int m_ch;
  int m_rem;

  // Expected {sel[1:0], sel_valid, busy, ch_done} for the upcoming sample.
  logic [4:0] exp_q[$];

  mux4_sel_sequencer #(.DWELL_W(DWELL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .en_mask   (en_mask),
    .dwell     (dwell),
    .s1        (s1),
    .s0        (s0),
    .sel_valid (sel_valid),
    .busy      (busy),
    .ch_done   (ch_done)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int lowest_enabled(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic int next_enabled(input logic [3:0] m, input int from);
    int idx;
    for (int k = 1; k <= 4; k++) begin
      idx = (from + k) % 4;
      if (m[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step(input bit st, input bit sp, input logic [3:0] m, input int d);
    int dl;
    int n;
    dl = (d == 0) ? 1 : d;
    if (m_run) begin
      if (sp) begin
        m_run = 0;
      end else if (m_rem == 1) begin
        n = next_enabled(m, m_ch);
        if (n < 0) m_run = 0;
        else begin
          m_ch  = n;
          m_rem = dl;
        end
      end else begin
        m_rem = m_rem - 1;
      end
    end else if (st && !sp && m != 4'b0000) begin
      m_run = 1;
      m_ch  = lowest_enabled(m);
      m_rem = dl;
    end
  endtask

  function automatic logic [4:0] model_out();
    logic [1:0] sel;
    logic       v;
    logic       done;
    sel  = 2'(m_ch);
    v    = m_run;
    done = m_run && (m_rem == 1);
    return {sel, v, v, done};
  endfunction

  task automatic model_reset();
    m_run = 0;
    m_ch  = 0;
    m_rem = 0;
    exp_q.delete();
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic compare_outputs();
    logic [4:0] e;
    if (exp_q.size() == 0) begin
      check_eq("exp_q_empty", 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check_eq("sel",       32'({s1, s0}),  32'(e[4:3]));
    check_eq("sel_valid", 32'(sel_valid), 32'(e[2]));
    check_eq("busy",      32'(busy),      32'(e[1]));
    check_eq("ch_done",   32'(ch_done),   32'(e[0]));
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge: drive inputs, advance the model,
  // let the rising edge happen, and compare on the next falling edge.
  task automatic cycle(input bit st, input bit sp, input logic [3:0] m, input int d);
    start   = st;
    stop    = sp;
    en_mask = m;
    dwell   = DWELL_W'(d);
    model_step(st, sp, m, d);
    exp_q.push_back(model_out());
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic go_idle();
    cycle(0, 1, 4'b0000, 1);
    cycle(0, 0, 4'b0000, 1);
  endtask

  // ---------------- stimulus ----------------
  logic [1:0] rot_sel[13];
  logic       rot_done[13];

  initial begin
    logic [3:0] rm;
    int         rd;

    rot_sel  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2,
                 2'd3, 2'd3, 2'd3, 2'd0};
    rot_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                 1'b0, 1'b0, 1'b1, 1'b0};

    rst_n   = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    en_mask = 4'b0000;
    dwell   = '0;
    model_reset();
    #2;
    check_eq("rst_sel",   32'({s1, s0}),  32'd0);
    check_eq("rst_valid", 32'(sel_valid), 32'd0);
    check_eq("rst_busy",  32'(busy),      32'd0);
    check_eq("rst_done",  32'(ch_done),   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0, 4'b0000, 0);

    // Full rotation: start at edge 0, sample i+1 is cycle i+1.
    for (int i = 0; i < 13; i++) begin
      cycle(i == 0, 0, 4'b1111, 3);
      check_eq("rot_sel",  32'({s1, s0}), 32'(rot_sel[i]));
      check_eq("rot_done", 32'(ch_done),  32'(rot_done[i]));
    end
    go_idle();

    // Sparse mask with wrap, then a single enabled channel.
    for (int i = 0; i < 8; i++) cycle(i == 0, 0, 4'b1010, 2);
    go_idle();
    for (int i = 0; i < 8; i++) cycle(i == 0, 0, 4'b0100, 2);
    go_idle();

    // Dwell of zero behaves as one: new channel every cycle.
    for (int i = 0; i < 6; i++) cycle(i == 0, 0, 4'b1111, 0);
    go_idle();

    // Mask cleared mid-dwell: channel 0 holds through cycle 4, idle in cycle 5.
    for (int i = 0; i < 7; i++) cycle(i == 0, 0, (i >= 2) ? 4'b0000 : 4'b0011, 4);
    check_eq("mask_clr_sel", 32'({s1, s0}), 32'd0);
    go_idle();

    // start together with stop in IDLE, then start with an empty mask.
    cycle(1, 1, 4'b1111, 2);
    cycle(0, 0, 4'b1111, 2);
    check_eq("start_stop_idle", 32'(sel_valid), 32'd0);
    cycle(1, 0, 4'b0000, 2);
    cycle(0, 0, 4'b0000, 2);
    check_eq("start_no_mask", 32'(busy), 32'd0);

    // stop in the ch_done cycle on channel 2.
    cycle(1, 0, 4'b0100, 2);
    cycle(0, 0, 4'b0100, 2);
    check_eq("stop_done_flag", 32'(ch_done), 32'd1);
    cycle(0, 1, 4'b0100, 2);
    check_eq("stop_hold_sel", 32'({s1, s0}), 32'd2);
    cycle(0, 0, 4'b0100, 2);

    // start while running has no effect.
    for (int i = 0; i < 10; i++) cycle(1, 0, 4'b1111, 3);
    go_idle();

    // Reset mid-run: outputs drop without any clock edge.
    cycle(1, 0, 4'b1111, 5);
    cycle(0, 0, 4'b1111, 5);
    cycle(0, 0, 4'b1111, 5);
    check_eq("pre_rst_valid", 32'(sel_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_sel",   32'({s1, s0}),  32'd0);
    check_eq("midrst_valid", 32'(sel_valid), 32'd0);
    check_eq("midrst_busy",  32'(busy),      32'd0);
    check_eq("midrst_done",  32'(ch_done),   32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(0, 0, 4'b1111, 5);

    // Random traffic.
    rm = 4'b1111;
    rd = 2;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) rm = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) rd = $urandom_range(0, 4);
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0, rm, rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_sel_sequencer.md
# mux4_sel_sequencer

Drives the `s1`/`s0` select pair of the 4:1 channel mux directly upstream of it, stepping through the enabled input channels (a=0, b=1, c=2, d=3).
- Each enabled channel is held for a programmable dwell count, then the sequencer advances to the next enabled channel in round-robin order.
- Software, or a higher-level controller, starts and stops the sequence with single-cycle pulses.
- `sel_valid` tells downstream logic that the mux output currently reflects a deliberately selected channel.

## Interface
- `DWELL_W`, default 8: width of the dwell count.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `start` in 1: one-cycle pulse; begins sequencing when in IDLE.
- `stop` in 1: one-cycle pulse; ends sequencing. Has priority over `start`.
- `en_mask` in 4: bit i=1 means channel i participates. Sampled live at every channel selection.
- `dwell` in DWELL_W: cycles per channel. Sampled at every channel load. Value 0 is treated as 1.
- `s1` out 1: select MSB. Channel index = {s1,s0}.
- `s0` out 1: select LSB.
- `sel_valid` out 1: high while in RUN.
- `busy` out 1: high while in RUN. Identical to `sel_valid`; kept separate for control-path fan-out.
- `ch_done` out 1: high during the last dwell cycle of the current channel, while in RUN.

## Operation
- States: IDLE, RUN.
- Internal registers:
  - `cur_ch[1:0]`, the current channel.
  - `cnt[DWELL_W-1:0]`, cycles remaining in the current dwell.
- IDLE → RUN: `start`=1, `stop`=0, `en_mask`≠0.
  - `cur_ch` is loaded with the lowest-index enabled channel.
  - `cnt` is loaded with max(`dwell`,1).
- `start` with `en_mask`=0 is ignored; the block stays in IDLE.
- RUN, `cnt`>1: `cnt` decrements; `cur_ch` holds.
- RUN, `cnt`=1 (`ch_done`=1), advance:
  - The next channel is the first enabled index found searching upward from `cur_ch`+1, wrapping mod 4, with `cur_ch` itself checked last.
  - `cnt` reloads with max(`dwell`,1).
- Single enabled channel: the advance reselects the same channel, `cnt` reloads, and `ch_done` pulses every dwell period.
- Advance with `en_mask`=0: RUN → IDLE. `sel_valid`/`busy` drop; `s1`/`s0` hold their last value.
- `stop`=1 in RUN: the next state is IDLE; `s1`/`s0` hold. If `cnt`=1 in that same cycle, `ch_done` is still high that cycle.
- `start` in RUN is ignored. `start`+`stop` together in IDLE: the block stays in IDLE.
- `{s1,s0}` = `cur_ch` at all times.
- `ch_done` = (state==RUN && `cnt`==1), decoded from registers only. No combinational input-to-output path exists anywhere.

## Timing
- Reset values:
  - `s1`=0, `s0`=0, `sel_valid`=0, `busy`=0, `ch_done`=0.
  - state=IDLE, `cnt`=0, `cur_ch`=0.
  - Outputs take these values immediately on `rst_n` falling, including mid-RUN.
- Latency: `start` sampled at edge N → `sel_valid`=1 and the new select valid after edge N, i.e. in cycle N+1.
- Each channel is presented for exactly max(`dwell`,1) cycles, with no gap cycles between channels.
- `stop` sampled at edge N → `sel_valid`=0 in cycle N+1.
- A mask change takes effect only at the next advance; the current dwell is never truncated.
- `dwell` change takes effect only at the next load.
- `cnt` never wraps: it is loaded with ≥1 and decremented only while >1.

## Structure
- Shared package `mux4_pkg`:
  - `NUM_CH`=4.
  - `ch_idx_t` (logic [1:0]).
  - `seq_state_e` enum {IDLE, RUN}.
- Sub-module `mux4_next_ch`: purely combinational rotate-priority picker.
  - Inputs: `en_mask[3:0]`, `base[1:0]`.
  - Outputs: `next[1:0]`, `none`.
  - Instantiated twice: once with base=3 for the start search (yields the lowest index first), once with base=`cur_ch` for the advance search.
- FSM, counter and output registers live in `mux4_sel_sequencer`.

## Test plan
- Reset mid-run: start with `en_mask`=4'b1111, `dwell`=5, assert `rst_n`=0 in cycle 3 → all outputs 0 immediately, no clock edge needed. After release the block stays in IDLE until a new `start`.
- Full rotation: `en_mask`=4'b1111, `dwell`=3, `start` at edge 0 → {s1,s0} is:
  - 0 in cycles 1–3, 1 in cycles 4–6, 2 in cycles 7–9, 3 in cycles 10–12, 0 again at cycle 13.
  - `ch_done` is high in cycles 3, 6, 9, 12.
- Sparse mask/wrap: `en_mask`=4'b1010, `dwell`=2 → select sequence 1,1,3,3,1,1. Same with `en_mask`=4'b0100 → select stays 2, `ch_done` every 2nd cycle.
- `dwell`=0: `en_mask`=4'b1111 → select changes every cycle (0,1,2,3,0), `ch_done` constantly 1.
- Mask cleared: `en_mask`=4'b0011, `dwell`=4, clear the mask in cycle 2 → channel 0 still held through cycle 4. In cycle 5, `sel_valid`/`busy`=0 and {s1,s0}=0 holds.
- Control conflicts, each checked separately:
  - `start`+`stop` in IDLE → stays IDLE.
  - `start` with `en_mask`=0 → stays IDLE.
  - `stop` in a `ch_done` cycle while on channel 2 → `ch_done`=1 that cycle, then IDLE with {s1,s0}=2.
  - `start` in RUN → no effect on sequence or count.
